// File: rtl/uart_rx_sampler.sv
// 8N1 UART receiver: 2-flop synchronizer, start-bit glitch rejection, mid-bit
// sampling, framing-error and overrun pulses, valid/ready byte output.
module uart_rx_sampler #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          rx_meta_q, rx_s_q, rx_d_q;
  logic [7:0]    data_q;
  logic          valid_q, ferr_q, ovr_q, busy_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_d_q    <= 1'b1;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_d_q    <= rx_s_q;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      // Plain consumption; a delivery in STOP below overrides this.
      if (valid_q && rx_ready) valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          // Requires a high-to-low transition, so a held break never retriggers.
          if (rx_d_q && !rx_s_q) begin
            state_q <= START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            if (!rx_s_q) begin
              state_q   <= DATA;
              bit_idx_q <= '0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q              <= '0;
            shift_q[bit_idx_q] <= rx_s_q;
            if (bit_idx_q == 3'd7) state_q <= STOP;
            else                   bit_idx_q <= bit_idx_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (!rx_s_q) begin
              ferr_q <= 1'b1;
            end else if (valid_q && !rx_ready) begin
              ovr_q <= 1'b1;
            end else begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed + randomized bench for uart_rx_sampler; expected bytes come from a
// queue of what was transmitted, timing from the bit-period arithmetic.
module tb_uart_rx_sampler;
  localparam int CPB = 16;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] got_q[$];
  int         got_t[$];
  int fe_cnt = 0, ov_cnt = 0, vld_cnt = 0, busy_cnt = 0, ov_t = 0;

  uart_rx_sampler #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rx_ready(rx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observer: inputs change at negedge+1, so everything is stable here.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && rx_ready) begin
        got_q.push_back(rx_data);
        got_t.push_back(cyc);
      end
      if (frame_err) fe_cnt++;
      if (overrun) begin ov_cnt++; ov_t = cyc; end
      if (rx_valid) vld_cnt++;
      if (busy) busy_cnt++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b, input logic stop, output int t_fall);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    t_fall = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (CPB) tick();
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear();
    got_q.delete();
    got_t.delete();
  endtask

  function automatic logic [7:0] got(input int i);
    return (i < got_q.size()) ? got_q[i] : 8'hxx;
  endfunction

  function automatic int gott(input int i);
    return (i < got_t.size()) ? got_t[i] : -100000;
  endfunction

  // Stop sample lands HALF + 9 bit periods after START entry, which is
  // 2..3 cycles (plus sampling phase) after the line falls.
  function automatic logic lat_ok(input int t_evt, input int t_fall);
    int d;
    d = t_evt - t_fall;
    return (d >= CPB / 2 + 9 * CPB + 2) && (d <= CPB / 2 + 9 * CPB + 4);
  endfunction

  initial begin
    int t, t1, t2, v0, b0, f0, o0, efe;
    logic [7:0] bytes4 [4];
    logic [7:0] exp_q[$];
    logic [7:0] rb;
    logic [9:0] f;
    logic bad;

    // Reset
    rst_n = 1'b0; rx_ready = 1'b1; rx = 1'b1;
    repeat (5) tick();
    chk("reset_outputs", {20'd0, rx_valid, frame_err, overrun, busy, rx_data}, 32'd0);
    rst_n = 1'b1;
    idle(10);

    // Single byte
    clear(); v0 = vld_cnt; f0 = fe_cnt; o0 = ov_cnt;
    send(8'hA5, 1'b1, t);
    idle(20);
    chk("single_count", got_q.size(), 1);
    chk("single_data", got(0), 8'hA5);
    chk("single_valid_width", vld_cnt - v0, 1);
    chk("single_latency", lat_ok(gott(0), t), 1);
    chk("single_no_err", {fe_cnt - f0, ov_cnt - o0}, 0);

    // Back-to-back
    clear();
    bytes4[0] = 8'h00; bytes4[1] = 8'hFF; bytes4[2] = 8'h3C; bytes4[3] = 8'h81;
    for (int i = 0; i < 4; i++) send(bytes4[i], 1'b1, t);
    idle(20);
    chk("b2b_count", got_q.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("b2b_data%0d", i), got(i), bytes4[i]);
    for (int i = 1; i < 4; i++) chk($sformatf("b2b_spacing%0d", i), gott(i) - gott(i-1), FRAME);

    // Glitch rejection
    clear(); b0 = busy_cnt; f0 = fe_cnt;
    rx = 1'b0;
    repeat (4) tick();
    idle(40);
    chk("glitch_busy_short", (busy_cnt - b0 > 0) && (busy_cnt - b0 <= 8), 1);
    chk("glitch_no_byte", got_q.size(), 0);
    chk("glitch_no_ferr", fe_cnt - f0, 0);
    send(8'h5A, 1'b1, t);
    idle(20);
    chk("glitch_next", got(0), 8'h5A);

    // Framing error
    clear(); f0 = fe_cnt;
    send(8'h77, 1'b0, t);
    idle(20);
    chk("ferr_pulse", fe_cnt - f0, 1);
    chk("ferr_no_byte", got_q.size(), 0);
    chk("ferr_valid_low", rx_valid, 0);
    send(8'h12, 1'b1, t);
    idle(20);
    chk("ferr_next", got(0), 8'h12);

    // Overrun and backpressure
    clear(); o0 = ov_cnt; f0 = fe_cnt;
    rx_ready = 1'b0;
    send(8'h11, 1'b1, t1);
    send(8'h22, 1'b1, t2);
    idle(20);
    chk("ovr_valid_held", rx_valid, 1);
    chk("ovr_data_held", rx_data, 8'h11);
    chk("ovr_pulse", ov_cnt - o0, 1);
    chk("ovr_timing", lat_ok(ov_t, t2), 1);
    chk("ovr_no_ferr", fe_cnt - f0, 0);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    tick();
    chk("ovr_consumed", rx_valid, 0);
    chk("ovr_data_kept", rx_data, 8'h11);
    rx_ready = 1'b1;
    idle(5);

    // Reset mid-frame, during data bit 4 of 0xC3
    clear(); f0 = fe_cnt; o0 = ov_cnt;
    f = {1'b1, 8'hC3, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rx = f[i];
      repeat (CPB) tick();
    end
    rx = f[5];
    repeat (CPB / 2) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rx = 1'b1;
    chk("midrst_outputs", {20'd0, rx_valid, frame_err, overrun, busy, rx_data}, 32'd0);
    idle(2 * FRAME);
    chk("midrst_no_byte", got_q.size(), 0);
    chk("midrst_no_flags", {fe_cnt - f0, ov_cnt - o0}, 0);
    send(8'h96, 1'b1, t);
    idle(20);
    chk("midrst_next", got(0), 8'h96);

    // Randomized stream with occasional bad stop bits and random gaps
    clear(); exp_q.delete(); f0 = fe_cnt; efe = 0;
    for (int i = 0; i < 12; i++) begin
      rb = 8'($urandom);
      bad = ($urandom_range(0, 5) == 0);
      send(rb, !bad, t);
      if (bad) efe++;
      else exp_q.push_back(rb);
      idle(bad ? $urandom_range(2, 30) : $urandom_range(0, 30));
    end
    idle(20);
    chk("rand_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) chk($sformatf("rand_data%0d", i), got(i), exp_q[i]);
    chk("rand_ferr", fe_cnt - f0, efe);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
